pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush controller for the 5-stage pipeline. Drives en_*/flush_* of the

---
 rtl/cpu_types_pkg.sv | 25 ++
 rtl/pipeline_hazard_ctrl_sat_counter.sv | 27 ++
 rtl/pipeline_hazard_ctrl.sv | 121 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: hazard controller FSM states, register index type
// and the load-use hazard detector used by the stall/flush controller.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        HALTED  = 2'd2
    } hazard_state_t;

    typedef logic [4:0] regbits_t;

    localparam regbits_t REG_ZERO = 5'd0;

    // $zero never carries a real dependency, so a load targeting it cannot stall
    function automatic logic load_use_hazard(
        input logic     dren_ex,
        input regbits_t rt_ex,
        input regbits_t rs_dec,
        input regbits_t rt_dec
    );
        return dren_ex && (rt_ex != REG_ZERO) && ((rt_ex == rs_dec) || (rt_ex == rt_dec));
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the hazard controller performance counters;
// holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             inc,
    output logic [CNT_W-1:0] out
);

    logic [CNT_W-1:0] count_r;

    // count register, frozen once it reaches all-ones
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count_r <= '0;
        end else if (inc && (count_r != {CNT_W{1'b1}})) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign out = count_r;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: resolves memory waits,
// load-use hazards, redirects and halt, and keeps stall/flush event counters.
module pipeline_hazard_ctrl
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dREN_mem,
    input  logic             dWEN_mem,
    input  logic             dREN_ex,
    input  regbits_t         rt_ex,
    input  regbits_t         rs_dec,
    input  regbits_t         rt_dec,
    input  logic             redirect_mem,
    input  logic             halt_mem,
    output logic             pc_en,
    output logic             en_fd,
    output logic             en_de,
    output logic             en_em,
    output logic             en_mw,
    output logic             flush_fd,
    output logic             flush_de,
    output logic             flush_em,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    hazard_state_t state_r;
    hazard_state_t next_state_s;
    logic          dmem_miss_s;
    logic          load_use_s;
    logic          redirect_s;
    logic          stall_inc_s;

    assign dmem_miss_s = (dREN_mem || dWEN_mem) && !dhit;
    assign load_use_s  = load_use_hazard(dREN_ex, rt_ex, rs_dec, rt_dec);

    // FSM state register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= RUN;
        end else begin
            state_r <= next_state_s;
        end
    end

    // next state and latch controls; a flush is always paired with en=0 because
    // the latches let enable win over flush
    always_comb begin
        next_state_s = state_r;
        pc_en        = 1'b0;
        en_fd        = 1'b0;
        en_de        = 1'b0;
        en_em        = 1'b0;
        en_mw        = 1'b0;
        flush_fd     = 1'b0;
        flush_de     = 1'b0;
        flush_em     = 1'b0;
        halt         = 1'b0;
        redirect_s   = 1'b0;
        case (state_r)
            HALTED: begin
                halt         = 1'b1;
                next_state_s = HALTED;
            end
            RUN, MEMWAIT: begin
                if (dmem_miss_s) begin
                    next_state_s = MEMWAIT;
                end else if (halt_mem) begin
                    en_mw        = 1'b1;
                    next_state_s = HALTED;
                end else begin
                    next_state_s = RUN;
                    if (redirect_mem) begin
                        redirect_s = 1'b1;
                        pc_en      = 1'b1;
                        en_mw      = 1'b1;
                        flush_fd   = 1'b1;
                        flush_de   = 1'b1;
                        flush_em   = 1'b1;
                    end else if (load_use_s || !ihit) begin
                        flush_de = 1'b1;
                        en_em    = 1'b1;
                        en_mw    = 1'b1;
                    end else begin
                        pc_en = 1'b1;
                        en_fd = 1'b1;
                        en_de = 1'b1;
                        en_em = 1'b1;
                        en_mw = 1'b1;
                    end
                end
            end
            default: begin
                next_state_s = RUN;
            end
        endcase
    end

    assign stall_inc_s = !pc_en && (state_r != HALTED);

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .CLK  (CLK),
        .nRST (nRST),
        .inc  (stall_inc_s),
        .out  (stall_cycles)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .CLK  (CLK),
        .nRST (nRST),
        .inc  (redirect_s),
        .out  (flush_events)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with narrow counters so saturation is reachable.
module tb_pipeline_hazard_ctrl;
    import cpu_types_pkg::*;

    localparam int CNT_W = 4;

    logic             CLK = 1'b0;
    logic             nRST;
    logic             ihit, dhit, dREN_mem, dWEN_mem, dREN_ex;
    regbits_t         rt_ex, rs_dec, rt_dec;
    logic             redirect_mem, halt_mem;
    logic             pc_en, en_fd, en_de, en_em, en_mw;
    logic             flush_fd, flush_de, flush_em, halt;
    logic [CNT_W-1:0] stall_cycles, flush_events;

    int checks = 0;
    int errors = 0;

    pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .ihit         (ihit),
        .dhit         (dhit),
        .dREN_mem     (dREN_mem),
        .dWEN_mem     (dWEN_mem),
        .dREN_ex      (dREN_ex),
        .rt_ex        (rt_ex),
        .rs_dec       (rs_dec),
        .rt_dec       (rt_dec),
        .redirect_mem (redirect_mem),
        .halt_mem     (halt_mem),
        .pc_en        (pc_en),
        .en_fd        (en_fd),
        .en_de        (en_de),
        .en_em        (en_em),
        .en_mw        (en_mw),
        .flush_fd     (flush_fd),
        .flush_de     (flush_de),
        .flush_em     (flush_em),
        .halt         (halt),
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
    );

    always #5 CLK = ~CLK;

    // control vector order: pc_en en_fd en_de en_em en_mw flush_fd flush_de flush_em halt
    localparam logic [8:0] C_RUN    = 9'b1_1111_000_0;
    localparam logic [8:0] C_FREEZE = 9'b0_0000_000_0;
    localparam logic [8:0] C_STALL  = 9'b0_0011_010_0;
    localparam logic [8:0] C_REDIR  = 9'b1_0001_111_0;
    localparam logic [8:0] C_HLTMEM = 9'b0_0001_000_0;
    localparam logic [8:0] C_HALTED = 9'b0_0000_000_1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_ctl(input string tag, input logic [8:0] exp);
        check(tag, {23'd0, pc_en, en_fd, en_de, en_em, en_mw, flush_fd, flush_de, flush_em, halt},
              {23'd0, exp});
    endtask

    task automatic idle_inputs();
        ihit = 1'b1; dhit = 1'b0; dREN_mem = 1'b0; dWEN_mem = 1'b0; dREN_ex = 1'b0;
        rt_ex = 5'd0; rs_dec = 5'd0; rt_dec = 5'd0; redirect_mem = 1'b0; halt_mem = 1'b0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        idle_inputs();
        nRST = 1'b0;
        #2;
        @(negedge CLK);
        nRST = 1'b1;
        #1;
    endtask

    initial begin
        idle_inputs();
        nRST = 1'b0;
        #12;
        check_ctl("reset_ctl", C_RUN);
        check("reset_stall", 32'(stall_cycles), 32'd0);
        check("reset_flush", 32'(flush_events), 32'd0);
        check("reset_state", 32'(dut.state_r), 32'(RUN));
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        check_ctl("release_run", C_RUN);
        tick();

        // load-use on rs
        @(negedge CLK);
        dREN_ex = 1'b1; rt_ex = 5'd5; rs_dec = 5'd5; rt_dec = 5'd1;
        #1;
        check_ctl("loaduse_rs", C_STALL);
        tick();
        check("loaduse_cnt", 32'(stall_cycles), 32'd1);
        // load into $zero is not a hazard
        @(negedge CLK);
        rt_ex = 5'd0; rs_dec = 5'd0; rt_dec = 5'd0;
        #1;
        check_ctl("loaduse_zero", C_RUN);
        // load-use on rt
        @(negedge CLK);
        rt_ex = 5'd7; rs_dec = 5'd3; rt_dec = 5'd7;
        #1;
        check_ctl("loaduse_rt", C_STALL);
        tick();
        check("loaduse_cnt2", 32'(stall_cycles), 32'd2);
        // instruction miss
        @(negedge CLK);
        idle_inputs();
        ihit = 1'b0;
        #1;
        check_ctl("imiss", C_STALL);

        // dmem miss: 3 freeze cycles then dhit
        do_reset();
        @(negedge CLK);
        dREN_mem = 1'b1; dhit = 1'b0; dREN_ex = 1'b1; rt_ex = 5'd4; rs_dec = 5'd4;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_ctl("dmiss_freeze", C_FREEZE);
            tick();
            check("dmiss_state", 32'(dut.state_r), 32'(MEMWAIT));
            @(negedge CLK);
        end
        dREN_ex = 1'b0;
        dhit = 1'b1;
        #1;
        check_ctl("dmiss_hit", C_RUN);
        tick();
        check("dmiss_state_run", 32'(dut.state_r), 32'(RUN));
        check("dmiss_stall3", 32'(stall_cycles), 32'd3);

        // redirect masked by a store miss, taken on dhit
        @(negedge CLK);
        idle_inputs();
        dWEN_mem = 1'b1; redirect_mem = 1'b1;
        #1;
        check_ctl("redir_freeze", C_FREEZE);
        tick();
        check("redir_noflush_yet", 32'(flush_events), 32'd0);
        @(negedge CLK);
        dhit = 1'b1; dREN_ex = 1'b1; rt_ex = 5'd9; rt_dec = 5'd9;
        #1;
        check_ctl("redir_flush", C_REDIR);
        tick();
        check("redir_events", 32'(flush_events), 32'd1);
        check("redir_stall", 32'(stall_cycles), 32'd4);

        // halt
        @(negedge CLK);
        idle_inputs();
        halt_mem = 1'b1; redirect_mem = 1'b1;
        #1;
        check_ctl("halt_mem", C_HLTMEM);
        tick();
        check_ctl("halted", C_HALTED);
        @(negedge CLK);
        idle_inputs();
        redirect_mem = 1'b1; dREN_mem = 1'b1;
        #1;
        check_ctl("halted_ignore", C_HALTED);
        tick();
        tick();
        check("halted_stall", 32'(stall_cycles), 32'd5);
        check("halted_flush", 32'(flush_events), 32'd1);
        check_ctl("halted_sticky", C_HALTED);

        // reset mid-freeze
        do_reset();
        @(negedge CLK);
        dREN_mem = 1'b1; dhit = 1'b0;
        tick();
        check("freeze_state", 32'(dut.state_r), 32'(MEMWAIT));
        #2;
        nRST = 1'b0;
        #1;
        check("abort_state", 32'(dut.state_r), 32'(RUN));
        check("abort_stall", 32'(stall_cycles), 32'd0);
        @(negedge CLK);
        idle_inputs();
        nRST = 1'b1;

        // saturation with 20 stall cycles
        @(negedge CLK);
        ihit = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("sat_stall", 32'(stall_cycles), 32'd15);
        @(negedge CLK);
        nRST = 1'b0;
        #1;
        check("sat_reset", 32'(stall_cycles), 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        tick();
        tick();
        check("sat_restart", 32'(stall_cycles), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
